// File: rtl/int_ctrl_pkg.sv
// Shared types for the interrupt sequencing controller:
// FSM states and memory-stage source selector encodings.
package int_ctrl_pkg;

  localparam logic [1:0] SEL_PIPE  = 2'b00;
  localparam logic [1:0] SEL_PCH   = 2'b01;
  localparam logic [1:0] SEL_PCL   = 2'b10;
  localparam logic [1:0] SEL_FLAGS = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FLUSH      = 4'd1,
    S_PUSH_PCH   = 4'd2,
    S_PUSH_PCL   = 4'd3,
    S_PUSH_FLAGS = 4'd4,
    S_VECTOR     = 4'd5,
    S_POP_FLAGS  = 4'd6,
    S_POP_PCL    = 4'd7,
    S_POP_PCH    = 4'd8,
    S_POP_WAIT   = 4'd9,
    S_RESUME     = 4'd10
  } state_e;

  // Stack slot addressed by each push/pop state.
  function automatic logic [1:0] sel_of(input state_e s);
    logic [1:0] r;
    r = SEL_PIPE;
    case (s)
      S_PUSH_PCH,  S_POP_PCH:   r = SEL_PCH;
      S_PUSH_PCL,  S_POP_PCL:   r = SEL_PCL;
      S_PUSH_FLAGS, S_POP_FLAGS: r = SEL_FLAGS;
      default:                  r = SEL_PIPE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/interrupt_controller_edge.sv
// Rising-edge detector for the external interrupt line with a
// sticky pending bit; repeated edges collapse into one request.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clr_i,
  output logic pending_o
);

  logic irq_q;
  logic irq_d;
  logic pending_q;
  logic pending_d;
  logic edge_w;

  // A fresh edge wins over a same-cycle clear.
  always_comb begin
    irq_d     = irq_in;
    edge_w    = irq_in & ~irq_q;
    pending_d = edge_w | (pending_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer: flushes the front end, stacks
// PC and flags through the memory stage, and restores them on RTI.
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                irq_in,
  input  logic                ctrl_hazard,
  input  logic                rti_in,
  input  logic [2*DATA_W-1:0] pc_resume,
  input  logic [FLAG_W-1:0]   flags_in,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_o,
  output logic                if_flush_o,
  output logic                id_flush_o,
  output logic                int_mem_selector1,
  output logic                int_mem_selector2,
  output logic                int_push_o,
  output logic                int_pop_o,
  output logic [2*DATA_W-1:0] int_pc_o,
  output logic [FLAG_W-1:0]   int_flags_o,
  output logic                interrupt_o,
  output logic                ret_valid_o,
  output logic [2*DATA_W-1:0] ret_pc_o,
  output logic [FLAG_W-1:0]   ret_flags_o,
  output logic                in_isr_o
);

  localparam int PC_W = 2 * DATA_W;

  state_e state_q;
  state_e state_d;

  logic              pending;
  logic              go_irq;
  logic              go_rti;
  logic              in_isr_q;
  logic              in_isr_d;
  logic              rti_q;
  logic              rti_d;
  logic [PC_W-1:0]   int_pc_q;
  logic [PC_W-1:0]   int_pc_d;
  logic [FLAG_W-1:0] int_flags_q;
  logic [FLAG_W-1:0] int_flags_d;
  logic [PC_W-1:0]   ret_pc_q;
  logic [PC_W-1:0]   ret_pc_d;
  logic [FLAG_W-1:0] ret_flags_q;
  logic [FLAG_W-1:0] ret_flags_d;
  logic [1:0]        sel;

  irq_edge_latch u_edge (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .clr_i    (go_irq),
    .pending_o(pending)
  );

  // RTI outranks a pending irq; no nesting while in the ISR.
  always_comb begin
    go_rti = (state_q == S_IDLE) & rti_q & in_isr_q;
    go_irq = (state_q == S_IDLE) & pending
           & ~ctrl_hazard & ~in_isr_q & ~go_rti;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_rti) begin
          state_d = S_POP_FLAGS;
        end else if (go_irq) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:      state_d = S_PUSH_PCH;
      S_PUSH_PCH:   state_d = S_PUSH_PCL;
      S_PUSH_PCL:   state_d = S_PUSH_FLAGS;
      S_PUSH_FLAGS: state_d = S_VECTOR;
      S_VECTOR:     state_d = S_IDLE;
      S_POP_FLAGS:  state_d = S_POP_PCL;
      S_POP_PCL:    state_d = S_POP_PCH;
      S_POP_PCH:    state_d = S_POP_WAIT;
      S_POP_WAIT:   state_d = S_RESUME;
      S_RESUME:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    int_push_o  = 1'b0;
    int_pop_o   = 1'b0;
    interrupt_o = 1'b0;
    ret_valid_o = 1'b0;
    sel         = sel_of(state_q);
    unique case (state_q)
      S_FLUSH: begin
        stall_o    = 1'b1;
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
      end
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_FLAGS: begin
        stall_o    = 1'b1;
        id_flush_o = 1'b1;
        int_push_o = 1'b1;
      end
      S_POP_FLAGS, S_POP_PCL, S_POP_PCH: begin
        stall_o    = 1'b1;
        id_flush_o = 1'b1;
        int_pop_o  = 1'b1;
      end
      S_POP_WAIT: begin
        stall_o    = 1'b1;
        id_flush_o = 1'b1;
      end
      S_VECTOR: interrupt_o = 1'b1;
      S_RESUME: ret_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Pop data arrives one cycle behind its strobe.
  always_comb begin
    int_pc_d    = int_pc_q;
    int_flags_d = int_flags_q;
    ret_pc_d    = ret_pc_q;
    ret_flags_d = ret_flags_q;
    in_isr_d    = in_isr_q;
    rti_d       = rti_in & in_isr_q & (state_q == S_IDLE);
    unique case (state_q)
      S_FLUSH: begin
        int_pc_d    = pc_resume;
        int_flags_d = flags_in;
      end
      S_VECTOR:   in_isr_d = 1'b1;
      S_POP_PCL:  ret_flags_d = mem_rdata[FLAG_W-1:0];
      S_POP_PCH:  ret_pc_d = {ret_pc_q[PC_W-1:DATA_W], mem_rdata};
      S_POP_WAIT: ret_pc_d = {mem_rdata, ret_pc_q[DATA_W-1:0]};
      S_RESUME:   in_isr_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_isr_q    <= 1'b0;
      rti_q       <= 1'b0;
      int_pc_q    <= '0;
      int_flags_q <= '0;
      ret_pc_q    <= '0;
      ret_flags_q <= '0;
    end else begin
      in_isr_q    <= in_isr_d;
      rti_q       <= rti_d;
      int_pc_q    <= int_pc_d;
      int_flags_q <= int_flags_d;
      ret_pc_q    <= ret_pc_d;
      ret_flags_q <= ret_flags_d;
    end
  end

  assign int_mem_selector1 = sel[0];
  assign int_mem_selector2 = sel[1];
  assign int_pc_o          = int_pc_q;
  assign int_flags_o       = int_flags_q;
  assign ret_pc_o          = ret_pc_q;
  assign ret_flags_o       = ret_flags_q;
  assign in_isr_o          = in_isr_q;

endmodule
